logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/logic_unit_arbiter_if.sv | 30 +++
 rtl/logic_unit.sv | 27 ++
 rtl/logic_unit_arbiter.sv | 105 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the logic unit and its round-robin arbiter:
//   opcode constants, the default datapath width and the output buffer
//   state encoding.
package logic_unit_pkg;

  localparam int LU_WIDTH = 20;

  localparam logic [1:0] LU_AND  = 2'b00;  // a & b
  localparam logic [1:0] LU_OR   = 2'b01;  // a | b
  localparam logic [1:0] LU_XOR  = 2'b10;  // a ^ b
  localparam logic [1:0] LU_ANDN = 2'b11;  // a & ~b

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if
//   Request/response bundle between NREQ requesters and the shared logic
//   unit arbiter. Requester i uses req_op[2i+:2], req_a/req_b[WIDTH*i+:WIDTH].
//   master : requester/consumer side (drives req_*, rsp_ready)
//   slave  : arbiter side (drives req_ready, rsp_*)
interface logic_unit_arbiter_if #(
  parameter int WIDTH = logic_unit_pkg::LU_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/logic_unit.sv
// logic_unit
//   Purely combinational WIDTH-bit bitwise unit.
//   op_i : opcode (LU_AND / LU_OR / LU_XOR / LU_ANDN)
//   a_i  : operand a
//   b_i  : operand b
//   y_o  : result, exactly WIDTH bits, no flags
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      LU_AND:  y_o = a_i & b_i;
      LU_OR:   y_o = a_i | b_i;
      LU_XOR:  y_o = a_i ^ b_i;
      LU_ANDN: y_o = a_i & ~b_i;
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Round-robin arbiter sharing one logic_unit between NREQ requesters,
//   with a one-entry registered result buffer supporting backpressure.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : logic_unit_arbiter_if.slave (req_valid/ready/op/a/b, rsp_*)
//   WIDTH/NREQ/IDW must match the parameters of the connected interface.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);
  buf_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q,   ptr_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [IDW-1:0]   id_q,    id_d;

  logic             can_accept;
  logic             found;
  logic             grant;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     idx;
  logic [NREQ-1:0]  ready;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, lu_y;

  // First valid requester at or after ptr, wrapping past NREQ-1.
  // Extra top bit on idx keeps ptr+k from overflowing before the wrap.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
  end

  // Gating with rst holds req_ready low for the whole reset, even though
  // the buffer already reads as EMPTY.
  assign can_accept = (state_q == BUF_EMPTY) || bus.rsp_ready;
  assign grant      = can_accept && found && !rst;

  always_comb begin
    ready = '0;
    if (grant) ready[gnt_idx] = 1'b1;
  end
  assign bus.req_ready = ready;

  assign sel_op = bus.req_op[2*gnt_idx +: 2];
  assign sel_a  = bus.req_a[WIDTH*gnt_idx +: WIDTH];
  assign sel_b  = bus.req_b[WIDTH*gnt_idx +: WIDTH];

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op_i (sel_op),
    .a_i  (sel_a),
    .b_i  (sel_b),
    .y_o  (lu_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (grant) begin
      // Covers both load-into-empty and drain-and-refill in one cycle.
      state_d = BUF_FULL;
      data_d  = lu_y;
      id_d    = gnt_idx;
      ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == BUF_FULL && bus.rsp_ready) begin
      state_d = BUF_EMPTY;  // data/id keep their last values
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.rsp_valid = (state_q == BUF_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int WIDTH = 20;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic_unit_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op[2*i +: 2]     = op;
    bus.req_a[WIDTH*i +: WIDTH] = a;
    bus.req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // Reference: requester i issues op i with a = 0x11111*(i+1), b = 0x0F0F0
  function automatic logic [WIDTH-1:0] ref_res(input int i);
    logic [WIDTH-1:0] a, b;
    a = 20'h11111 * (i + 1);
    b = 20'h0F0F0;
    case (i)
      0: ref_res = a & b;
      1: ref_res = a | b;
      2: ref_res = a ^ b;
      default: ref_res = a & ~b;
    endcase
  endfunction

  logic [WIDTH-1:0] allops_exp [4];

  initial begin
    allops_exp[0] = 20'h0F0F0;
    allops_exp[1] = 20'hFFFFF;
    allops_exp[2] = 20'hF0F0F;
    allops_exp[3] = 20'hF0F0F;

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset, with requests pending
    #1 rst = 1'b1;
    bus.req_valid = 4'hF;
    tick(); tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    bus.req_valid = '0;

    // Single request
    set_req(0, 2'b00, 20'hAAAAA, 20'h55555);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1 chk("single_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_data",  32'(bus.rsp_data),  32'h00000);
    chk("single_id",    32'(bus.rsp_id),    32'd0);

    // All ops back to back from requester 2
    bus.req_valid = 4'b0100;
    for (int op = 0; op < 4; op++) begin
      set_req(2, 2'(op), 20'hFFFFF, 20'h0F0F0);
      #1 chk("allops_req_ready", 32'(bus.req_ready), 32'h4);
      tick();
      chk("allops_valid", 32'(bus.rsp_valid), 32'd1);
      chk("allops_data",  32'(bus.rsp_data),  32'(allops_exp[op]));
      chk("allops_id",    32'(bus.rsp_id),    32'd2);
    end
    bus.req_valid = '0;
    tick();
    chk("drain_empty", 32'(bus.rsp_valid), 32'd0);

    // Round-robin, all valid from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 2'(i), 20'h11111 * (i + 1), 20'h0F0F0);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_id",   32'(bus.rsp_id),   32'(k % 4));
      chk("rr_data", 32'(bus.rsp_data), 32'(ref_res(k % 4)));
    end

    // Round-robin with gaps (ptr back at 0)
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("gap_id", 32'(bus.rsp_id), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Backpressure: buffer holds requester 3's result
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_id",    32'(bus.rsp_id),    32'd3);
      chk("bp_data",  32'(bus.rsp_data),  32'(ref_res(3)));
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_release_id",    32'(bus.rsp_id),    32'd0);
    chk("bp_release_data",  32'(bus.rsp_data),  32'(ref_res(0)));

    // Reset mid-operation while FULL and stalled
    bus.rsp_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid",     32'(bus.rsp_valid), 32'd0);
    chk("mrst_data",      32'(bus.rsp_data),  32'd0);
    chk("mrst_id",        32'(bus.rsp_id),    32'd0);
    chk("mrst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
    #1 chk("mrst_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mrst_first_id", 32'(bus.rsp_id), 32'd0);
    tick();
    chk("mrst_second_id", 32'(bus.rsp_id), 32'd3);
    bus.req_valid = '0;
    tick();
    chk("hold_after_drain_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold_after_drain_id",    32'(bus.rsp_id),    32'd3);
    chk("hold_after_drain_data",  32'(bus.rsp_data),  32'(ref_res(3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
